// File: rtl/gray_sweep_ctrl.sv
// Built-in self-check sequencer: sweeps every WIDTH-bit code into a binary-to-Gray
// converter and checks single-bit adjacency. Optional cyclic check: GRAY_SWEEP_WRAP_CHECK_EN.
module gray_sweep_ctrl #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] g_in,
  output logic [WIDTH-1:0] x_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_idx,
  output logic [WIDTH:0]   pass_cnt
);

`ifdef GRAY_SWEEP_WRAP_CHECK_EN
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_CHECK, S_WRAP, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;
`endif

  localparam int                CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]     SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [WIDTH-1:0]  LAST_CODE   = {WIDTH{1'b1}};

  state_t             state, next;
  logic [CW-1:0]      settle_cnt;
  logic [WIDTH-1:0]   prev_g;
  logic               launch;
  logic               chk_pass;
`ifdef GRAY_SWEEP_WRAP_CHECK_EN
  logic [WIDTH-1:0]   first_g;
  logic               wrap_pass;
`endif

  function automatic logic one_hot(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    m = v - WIDTH'(1);
    return (v != '0) && ((v & m) == '0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  always_comb begin
    next   = state;
    launch = 1'b0;
    busy   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next   = S_DRIVE;
          launch = 1'b1;
        end
      end
      S_DRIVE: begin
        busy = 1'b1;
        if (settle_cnt == SETTLE_LAST) next = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (x_out != LAST_CODE) next = S_DRIVE;
`ifdef GRAY_SWEEP_WRAP_CHECK_EN
        else                    next = S_WRAP;
`else
        else                    next = S_DONE;
`endif
      end
`ifdef GRAY_SWEEP_WRAP_CHECK_EN
      S_WRAP: begin
        busy = 1'b1;
        next = S_DONE;
      end
`endif
      S_DONE: begin
        if (start) begin
          next   = S_DRIVE;
          launch = 1'b1;
        end
      end
      default: next = S_IDLE;
    endcase
  end

  // Code 0 must read all-zero; later codes must differ from the previous read by one bit.
  always_comb begin
    chk_pass = (x_out == '0) ? (g_in == '0) : one_hot(g_in ^ prev_g);
  end

`ifdef GRAY_SWEEP_WRAP_CHECK_EN
  always_comb begin
    wrap_pass = one_hot(prev_g ^ first_g);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst || state != S_DRIVE || next != S_DRIVE) settle_cnt <= '0;
    else                                            settle_cnt <= settle_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_out    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_idx  <= '0;
      pass_cnt <= '0;
    end else if (launch) begin
      x_out    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_idx  <= '0;
      pass_cnt <= '0;
    end else if (state == S_CHECK) begin
      if (chk_pass) begin
        pass_cnt <= pass_cnt + (WIDTH+1)'(1);
      end else begin
        err <= 1'b1;
        if (!err) err_idx <= x_out;
      end
      if (x_out != LAST_CODE) x_out <= x_out + WIDTH'(1);
`ifndef GRAY_SWEEP_WRAP_CHECK_EN
      else                    done  <= 1'b1;
`endif
    end
`ifdef GRAY_SWEEP_WRAP_CHECK_EN
    else if (state == S_WRAP) begin
      if (!wrap_pass) begin
        err <= 1'b1;
        if (!err) err_idx <= '0;
      end
      done <= 1'b1;
    end
`endif
  end

  // Sampled converter history carries no control meaning, so it is left unreset.
  always_ff @(posedge clk) begin
    if (state == S_CHECK) prev_g <= g_in;
  end

`ifdef GRAY_SWEEP_WRAP_CHECK_EN
  always_ff @(posedge clk) begin
    if (state == S_CHECK && x_out == '0) first_g <= g_in;
  end
`endif

endmodule
